// File: rtl/sram_1r1w_tiled.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_1r1w_tiled : WIDTH x DEPTH 1R1W SRAM built from 1r1w macro tiles,   |
// | zero-init sweep after reset. Option: SRAM_RW_BYPASS_EN (same-addr fwd).  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module sram_1r1w_tiled_macro #(
  parameter int DW   = 32,
  parameter int AW   = 6,
  parameter int BYTE = 8
) (
  input  logic                 clk,
  input  logic                 csb0,
  input  logic [DW/BYTE-1:0]   wmask0,
  input  logic [AW-1:0]        addr0,
  input  logic [DW-1:0]        din0,
  input  logic                 csb1,
  input  logic [AW-1:0]        addr1,
  output logic [DW-1:0]        dout1
);
  logic [DW-1:0] r_mem [2**AW];

  // Read and write of the same row in one cycle returns the old contents.
  always_ff @(posedge clk) begin
    if (!csb0) begin
      for (int i = 0; i < DW/BYTE; i++) begin
        if (wmask0[i]) r_mem[addr0][i*BYTE +: BYTE] <= din0[i*BYTE +: BYTE];
      end
    end
    if (!csb1) dout1 <= r_mem[addr1];
  end
endmodule

module sram_1r1w_tiled #(
  parameter  int WIDTH       = 64,
  parameter  int DEPTH       = 256,
  parameter  int BYTE        = 8,
  parameter  int MACRO_WIDTH = 32,
  parameter  int MACRO_DEPTH = 64,
  localparam int ADDR_W      = $clog2(DEPTH),
  localparam int MASK_W      = WIDTH/BYTE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wen,
  input  logic [MASK_W-1:0] wmask,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              ren,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata,
  output logic              rvalid,
  output logic              ready
);
  localparam int NCOL   = WIDTH/MACRO_WIDTH;
  localparam int NBANK  = DEPTH/MACRO_DEPTH;
  localparam int ROW_W  = $clog2(MACRO_DEPTH);
  localparam int BANK_W = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam int MBYTES = MACRO_WIDTH/BYTE;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [ROW_W-1:0]              r_init_cnt;
  logic                          w_init;
  logic                          w_ready;
  logic [BANK_W-1:0]             w_wbank;
  logic [BANK_W-1:0]             w_rbank;
  logic [ROW_W-1:0]              w_addr0;
  logic [NBANK-1:0][WIDTH-1:0]   w_bank_dout;
  logic                          r_s1_valid;
  logic [BANK_W-1:0]             r_s1_bank;
  logic [WIDTH-1:0]              w_rd_merged;

  assign w_init  = (r_state == ST_INIT);
  assign w_ready = (r_state == ST_READY);
  assign ready   = w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_init) r_init_cnt <= r_init_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT:  if (r_init_cnt == ROW_W'(MACRO_DEPTH-1)) w_state_nxt = ST_READY;
      default:  w_state_nxt = r_state;
    endcase
  end

  generate
    if (NBANK > 1) begin : g_bank_dec
      assign w_wbank = waddr[ADDR_W-1:ROW_W];
      assign w_rbank = raddr[ADDR_W-1:ROW_W];
    end else begin : g_bank_one
      assign w_wbank = '0;
      assign w_rbank = '0;
    end
  endgenerate

  // During the sweep every macro is written at the same row in parallel.
  assign w_addr0 = w_init ? r_init_cnt : waddr[ROW_W-1:0];

  generate
    for (genvar b = 0; b < NBANK; b++) begin : g_bank
      logic w_csb1;
      assign w_csb1 = !(ren && w_ready && (w_rbank == BANK_W'(b)));

      for (genvar c = 0; c < NCOL; c++) begin : g_col
        logic                   w_csb0;
        logic [MBYTES-1:0]      w_wm;
        logic [MACRO_WIDTH-1:0] w_din;

        assign w_csb0 = w_init ? 1'b0 :
                        !(wen && (|wmask[c*MBYTES +: MBYTES]) && (w_wbank == BANK_W'(b)));
        assign w_wm   = w_init ? '1 : wmask[c*MBYTES +: MBYTES];
        assign w_din  = w_init ? '0 : wdata[c*MACRO_WIDTH +: MACRO_WIDTH];

        sram_1r1w_tiled_macro #(
          .DW   (MACRO_WIDTH),
          .AW   (ROW_W),
          .BYTE (BYTE)
        ) u_macro (
          .clk    (clk),
          .csb0   (w_csb0),
          .wmask0 (w_wm),
          .addr0  (w_addr0),
          .din0   (w_din),
          .csb1   (w_csb1),
          .addr1  (raddr[ROW_W-1:0]),
          .dout1  (w_bank_dout[b][c*MACRO_WIDTH +: MACRO_WIDTH])
        );
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_bank  <= '0;
    end else begin
      r_s1_valid <= ren && w_ready;
      r_s1_bank  <= w_rbank;
    end
  end

`ifdef SRAM_RW_BYPASS_EN
  logic              r_s1_byp;
  logic [MASK_W-1:0] r_s1_wmask;
  logic [WIDTH-1:0]  r_s1_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_byp   <= 1'b0;
      r_s1_wmask <= '0;
      r_s1_wdata <= '0;
    end else begin
      r_s1_byp   <= wen && ren && w_ready && (waddr == raddr);
      r_s1_wmask <= wmask;
      r_s1_wdata <= wdata;
    end
  end

  always_comb begin
    w_rd_merged = w_bank_dout[r_s1_bank];
    for (int i = 0; i < MASK_W; i++) begin
      if (r_s1_byp && r_s1_wmask[i]) w_rd_merged[i*BYTE +: BYTE] = r_s1_wdata[i*BYTE +: BYTE];
    end
  end
`else
  always_comb begin
    w_rd_merged = w_bank_dout[r_s1_bank];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= r_s1_valid;
      if (r_s1_valid) rdata <= w_rd_merged;
    end
  end
endmodule

`default_nettype wire

// File: doc/sram_1r1w_tiled.md
Name: sram_1r1w_tiled

Overview:
- Parametrised 1R1W SRAM wrapper for sky130 builds.
- Tiles fixed-size sky130 1r1w OpenRAM macros in width and depth to build an arbitrary WIDTH x DEPTH array with a byte-masked write port and a registered read port.
- Runs a hardware zero-initialisation sweep after reset.
- Used by cache tag/data arrays and predictor tables in place of per-size hand-written wrappers.

Parameters:
- WIDTH, 64: logical data width in bits. Must be a multiple of MACRO_WIDTH and of BYTE.
- DEPTH, 256: logical entries. Must be a multiple of MACRO_DEPTH.
- BYTE, 8: write-mask granularity in bits. MACRO_WIDTH must be a multiple of BYTE.
- MACRO_WIDTH, 32: data width of one macro.
- MACRO_DEPTH, 64: entries of one macro.
- Derived: ADDR_W = clog2(DEPTH), NCOL = WIDTH/MACRO_WIDTH, NBANK = DEPTH/MACRO_DEPTH, MASK_W = WIDTH/BYTE.

Ports:
- clk  in  1  clock for both macro ports and all wrapper flops.
- rst_n  in  1  asynchronous active-low reset.
- wen  in  1  write request.
- wmask  in  MASK_W  byte write enables. wen with wmask==0 is a no-op.
- waddr  in  ADDR_W  write address.
- wdata  in  WIDTH  write data.
- ren  in  1  read request.
- raddr  in  ADDR_W  read address.
- rdata  out  WIDTH  read data, registered.
- rvalid  out  1  rdata holds the result of a read issued 2 cycles earlier.
- ready  out  1  initialisation sweep done; requests accepted.

Behaviour:
- Reset (rst_n=0, async): FSM goes to INIT; init counter=0; ready=0; rvalid=0; rdata=0; pipeline valid and bank-select flops=0.
- FSM states:
  - INIT: each cycle writes 0 (full mask) to address init_cnt in every macro of every bank in parallel. init_cnt increments each cycle. When init_cnt==MACRO_DEPTH-1, go to READY next cycle.
  - Sweep takes exactly MACRO_DEPTH cycles after rst_n rises. ready=1 from the cycle after the last init write.
  - READY: normal operation. Terminal state; only reset leaves it.
  - rst_n asserted mid-sweep restarts the sweep from 0.
- While ready=0:
  - wen/ren are ignored. No macro access except init writes.
  - rvalid stays 0.
- Address decode:
  - bank = addr[ADDR_W-1 : clog2(MACRO_DEPTH)]; macro row = low bits.
  - Bank-select for macro write uses csb0 = !(wen & |wmask_col & bank_hit). Each column macro gets its own wmask slice.
  - Read selects only the addressed bank: csb1 = !(ren & bank_hit).
- Read pipeline:
  - Stage 0 (cycle N): ren/raddr sampled by the macro. read bank index and ren registered into s1.
  - Stage 1 (N+1): macro dout of bank s1_bank concatenated over columns, muxed, and registered into rdata.
  - rvalid = s2 valid. rdata valid and rvalid=1 at cycle N+2.
  - rdata holds its value when no read completes (rvalid=0); it does not clear.
- Back-to-back reads every cycle are supported at full throughput.
- Simultaneous wen and ren, different addresses: both proceed independently.
- Simultaneous wen and ren, same address: see optional feature. Without it, rdata returns the pre-write contents.
- Write takes effect at the clock edge. A read issued the next cycle or later observes it.
- Addresses are always in range by construction (DEPTH is a multiple of MACRO_DEPTH; no out-of-range check).

Optional Feature:
- Macro: SRAM_RW_BYPASS_EN.
- Defined:
  - The wrapper registers wen & ren & (waddr==raddr), plus wmask and wdata, into s1.
  - At stage 1 the macro output is merged byte-wise: each byte whose s1 wmask bit is 1 takes s1 wdata; others take the macro output.
  - A same-cycle write is thus visible in rdata 2 cycles later.
  - Adds WIDTH+MASK_W+1 flops.
- Undefined: no forwarding logic. Same-address same-cycle read returns old data.

Test Plan:
- Release rst_n; count cycles -> ready rises exactly MACRO_DEPTH(64) cycles after release. Then a read of every address returns 0 with rvalid=1 two cycles after each ren.
- Assert rst_n at cycle 20 of the sweep, then release -> sweep restarts. ready rises 64 cycles after the second release, not before. Reads/writes issued during the sweep have no effect and rvalid stays 0.
- WIDTH=64, DEPTH=256:
  - Write 0x1122334455667788 full mask to addr 0x05, and 0xAABBCCDD00000000 full mask to 0xC5 (bank 3).
  - Read 0x05 then 0xC5 on consecutive cycles -> rdata = 0x1122334455667788 at N+2 and 0xAABBCCDD00000000 at N+3.
- Write wmask=0x0F, wdata=0xFFFFFFFFFFFFFFFF to addr 0x05 (after the previous data) -> read returns 0x11223344FFFFFFFF.
- Same-cycle wen/ren at addr 0x10 (old 0), wdata=0x0123456789ABCDEF, wmask=0xF0:
  - with SRAM_RW_BYPASS_EN -> rdata=0x0123456700000000.
  - without it -> rdata=0.
  - A subsequent read returns 0x0123456700000000 in both builds.
- ren held high for 100 cycles over sequential addresses with random concurrent writes -> rvalid continuous after the 2-cycle fill. rdata matches the reference model each cycle.
